// File: rtl/mem_arbiter.sv
// Round-robin arbiter that lets several cache ports share one memory port.
// A granted request is registered onto the memory bus and held until accepted.
//
// state | meaning
// IDLE  | no transaction in flight; pick the next requester round-robin
// ISSUE | strobe, address and write data held on the memory bus until mem_ready
// RWAIT | read accepted; waiting for mem_r_data_valid to route data back
module mem_arbiter #(
    parameter int NumPorts     = 2,
    parameter int AddrBusWidth = 5,
    parameter int MemBusWidth  = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NumPorts-1:0][AddrBusWidth-1:0]   port_addr,
    input  logic [NumPorts-1:0][MemBusWidth-1:0]    port_w_data,
    input  logic [NumPorts-1:0]                     port_re,
    input  logic [NumPorts-1:0]                     port_we,
    output logic [NumPorts-1:0]                     port_ready,
    output logic [NumPorts-1:0][MemBusWidth-1:0]    port_r_data,
    output logic [NumPorts-1:0]                     port_r_data_valid,
    output logic [AddrBusWidth-1:0]                 mem_addr,
    output logic [MemBusWidth-1:0]                  mem_w_data,
    output logic                                    mem_re,
    output logic                                    mem_we,
    input  logic                                    mem_ready,
    input  logic [MemBusWidth-1:0]                  mem_r_data,
    input  logic                                    mem_r_data_valid
);

    localparam int GrantW = $clog2(NumPorts);
    localparam logic [GrantW-1:0] LastPort = GrantW'(NumPorts - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [GrantW-1:0]       grant_q, grant_d;
    logic [GrantW-1:0]       last_grant_q, last_grant_d;
    logic [AddrBusWidth-1:0] mem_addr_q, mem_addr_d;
    logic [MemBusWidth-1:0]  mem_w_data_q, mem_w_data_d;
    logic                    mem_re_q, mem_re_d;
    logic                    mem_we_q, mem_we_d;

    logic                    pick_valid;
    logic [GrantW-1:0]       pick_idx;
    logic [GrantW-1:0]       cand;

    function automatic logic [GrantW-1:0] wrap_idx(input logic [GrantW-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= NumPorts) s = s - NumPorts;
        return GrantW'(s);
    endfunction

    // Search begins one past the last grant, so a lone requester still wins every time.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= NumPorts; i++) begin
            cand = wrap_idx(last_grant_q, i);
            if (!pick_valid && (port_re[cand] || port_we[cand])) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        last_grant_d      = last_grant_q;
        mem_addr_d        = mem_addr_q;
        mem_w_data_d      = mem_w_data_q;
        mem_re_d          = mem_re_q;
        mem_we_d          = mem_we_q;
        port_ready        = '0;
        port_r_data       = '0;
        port_r_data_valid = '0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d      = pick_idx;
                    last_grant_d = pick_idx;
                    mem_addr_d   = port_addr[pick_idx];
                    mem_w_data_d = port_w_data[pick_idx];
                    // A port raising both strobes is treated as a write.
                    mem_we_d     = port_we[pick_idx];
                    mem_re_d     = port_re[pick_idx] & ~port_we[pick_idx];
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    port_ready[grant_q] = 1'b1;
                    mem_re_d            = 1'b0;
                    mem_we_d            = 1'b0;
                    state_d             = mem_we_q ? IDLE : RWAIT;
                end
            end
            RWAIT: begin
                if (mem_r_data_valid) begin
                    port_r_data_valid[grant_q] = 1'b1;
                    port_r_data[grant_q]       = mem_r_data;
                    state_d                    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst) begin
            port_ready        = '0;
            port_r_data       = '0;
            port_r_data_valid = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= LastPort;
            mem_addr_q   <= '0;
            mem_w_data_q <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mem_addr_q   <= mem_addr_d;
            mem_w_data_q <= mem_w_data_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_w_data = mem_w_data_q;
    assign mem_re     = mem_re_q;
    assign mem_we     = mem_we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_mem_arbiter;
    localparam int N  = 2;
    localparam int AW = 5;
    localparam int DW = 8;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [N-1:0][AW-1:0]   port_addr = '0;
    logic [N-1:0][DW-1:0]   port_w_data = '0;
    logic [N-1:0]           port_re = '0;
    logic [N-1:0]           port_we = '0;
    logic [N-1:0]           port_ready;
    logic [N-1:0][DW-1:0]   port_r_data;
    logic [N-1:0]           port_r_data_valid;
    logic [AW-1:0]          mem_addr;
    logic [DW-1:0]          mem_w_data;
    logic                   mem_re;
    logic                   mem_we;
    logic                   mem_ready = 1'b0;
    logic [DW-1:0]          mem_r_data = '0;
    logic                   mem_r_data_valid = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.NumPorts(N), .AddrBusWidth(AW), .MemBusWidth(DW)) dut (
        .clk(clk), .rst(rst),
        .port_addr(port_addr), .port_w_data(port_w_data),
        .port_re(port_re), .port_we(port_we),
        .port_ready(port_ready), .port_r_data(port_r_data),
        .port_r_data_valid(port_r_data_valid),
        .mem_addr(mem_addr), .mem_w_data(mem_w_data),
        .mem_re(mem_re), .mem_we(mem_we), .mem_ready(mem_ready),
        .mem_r_data(mem_r_data), .mem_r_data_valid(mem_r_data_valid)
    );

    typedef struct packed {
        logic          re;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    req_t q0[$];
    req_t q1[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // memory responder knobs
    int stall = 0;
    int rlat = 1;
    int pend = 0;
    int wcnt = 0;
    bit extra_valid = 1'b0;
    bit acc_rd = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] memory [32];
    logic [N-1:0] rdy_seen = '0;

    // observation logs
    int rdy_log[$];
    int rdy_cyc[$];
    int rv_port[$];
    int rv_data[$];
    int rv_cyc[$];
    int re_cycles = 0;
    int we_cycles = 0;

    // model state
    bit            m_active = 1'b0;
    bit            m_write = 1'b0;
    bit            m_acc = 1'b0;
    int            m_port = 0;
    int            m_last = N - 1;
    int            mp;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic req_t mk(input logic re, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_t r;
        r.re = re; r.we = we; r.addr = a; r.data = d;
        return r;
    endfunction

    always @(posedge clk) cyc++;

    // Model: one transaction at a time, round-robin from one past the last grant.
    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            m_acc    = 1'b0;
            m_last   = N - 1;
        end else if (!m_active) begin
            for (int i = 1; i <= N; i++) begin
                mp = (m_last + i) % N;
                if (!m_active && (port_re[mp] || port_we[mp])) begin
                    m_active = 1'b1;
                    m_write  = port_we[mp];
                    m_port   = mp;
                    m_addr   = port_addr[mp];
                    m_wdata  = port_w_data[mp];
                    m_acc    = 1'b0;
                    m_last   = mp;
                end
            end
        end else if (!m_acc) begin
            if (mem_ready) begin
                if (m_write) m_active = 1'b0;
                else         m_acc = 1'b1;
            end
        end else if (mem_r_data_valid) begin
            m_active = 1'b0;
        end
    end

    // Compare process plus logging and memory capture, away from the active edge.
    logic               exp_re, exp_we;
    logic [N-1:0]       exp_rdy, exp_rv;
    logic [N-1:0][DW-1:0] exp_rd;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_re  = m_active && !m_acc && !m_write;
            exp_we  = m_active && !m_acc && m_write;
            exp_rdy = '0;
            exp_rv  = '0;
            exp_rd  = '0;
            if (!rst && m_active && !m_acc && mem_ready) exp_rdy[m_port] = 1'b1;
            if (!rst && m_active && m_acc && mem_r_data_valid) begin
                exp_rv[m_port] = 1'b1;
                exp_rd[m_port] = mem_r_data;
            end
            chk("mem_strobes", {30'd0, mem_re, mem_we}, {30'd0, exp_re, exp_we});
            if (exp_re || exp_we) begin
                chk("mem_addr", 32'(mem_addr), 32'(m_addr));
                chk("mem_w_data", 32'(mem_w_data), 32'(m_wdata));
            end
            chk("port_ready", 32'(port_ready), 32'(exp_rdy));
            chk("port_r_data_valid", 32'(port_r_data_valid), 32'(exp_rv));
            chk("port_r_data", 32'(port_r_data), 32'(exp_rd));

            for (int p = 0; p < N; p++) begin
                if (port_ready[p]) begin
                    rdy_log.push_back(p);
                    rdy_cyc.push_back(cyc);
                end
                if (port_r_data_valid[p]) begin
                    rv_port.push_back(p);
                    rv_data.push_back(int'(port_r_data[p]));
                    rv_cyc.push_back(cyc);
                end
            end
            if (mem_re) re_cycles++;
            if (mem_we) we_cycles++;
            rdy_seen = port_ready;
            acc_rd   = mem_ready && mem_re;
            if (mem_ready && mem_re) rd_addr = mem_addr;
            if (mem_ready && mem_we) memory[mem_addr] = mem_w_data;
        end
    end

    // Requesters and memory responder, driven just after the active edge.
    always @(posedge clk) begin
        req_t f0, f1;
        bit   v;
        #1;
        if (rdy_seen[0] && q0.size() > 0) q0.delete(0);
        if (rdy_seen[1] && q1.size() > 0) q1.delete(0);
        f0 = (q0.size() > 0) ? q0[0] : '0;
        f1 = (q1.size() > 0) ? q1[0] : '0;
        port_re[0] = f0.re; port_we[0] = f0.we; port_addr[0] = f0.addr; port_w_data[0] = f0.data;
        port_re[1] = f1.re; port_we[1] = f1.we; port_addr[1] = f1.addr; port_w_data[1] = f1.data;

        v = 1'b0;
        if (rst) begin
            pend = 0;
            wcnt = 0;
            mem_ready = 1'b0;
        end else begin
            if (acc_rd) pend = rlat;
            if (pend > 0) begin
                pend--;
                if (pend == 0) v = 1'b1;
            end
            if (mem_re || mem_we) begin
                mem_ready = (wcnt >= stall);
                if (wcnt < stall) wcnt++;
            end else begin
                mem_ready = 1'b0;
                wcnt = 0;
            end
        end
        mem_r_data_valid = v | extra_valid;
        mem_r_data       = v ? memory[rd_addr] : 8'hEE;
    end

    task automatic clear_logs();
        rdy_log.delete(); rdy_cyc.delete();
        rv_port.delete(); rv_data.delete(); rv_cyc.delete();
        re_cycles = 0; we_cycles = 0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_active || pend > 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_done_in_budget"}, 32'(n < budget), 32'd1);
        repeat (2) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #2; rst = 1'b1;
        @(posedge clk); #2; rst = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        for (int i = 0; i < 32; i++) memory[i] = 8'(i * 3);
        @(posedge clk); #1; chk_en = 1'b1;
        @(negedge clk);
        chk("rst_mem_re", 32'(mem_re), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_w_data", 32'(mem_w_data), 32'd0);
        chk("rst_port_ready", 32'(port_ready), 32'd0);
        chk("rst_port_r_data", 32'(port_r_data), 32'd0);
        @(posedge clk); #2; rst = 1'b0;
        @(posedge clk);

        // Single read from port 1, memory ready at once, data two cycles later.
        clear_logs(); stall = 0; rlat = 2; memory[5'h1B] = 8'hA7;
        q1.push_back(mk(1'b1, 1'b0, 5'h1B, 8'h00));
        wait_idle("rd1", 40);
        chk("rd1_ready_count", rdy_log.size(), 1);
        chk("rd1_ready_port", rdy_log.size() > 0 ? rdy_log[0] : 99, 1);
        chk("rd1_valid_count", rv_port.size(), 1);
        chk("rd1_valid_port", rv_port.size() > 0 ? rv_port[0] : 99, 1);
        chk("rd1_data", rv_data.size() > 0 ? rv_data[0] : 999, 32'hA7);
        chk("rd1_latency", (rv_cyc.size() > 0 && rdy_cyc.size() > 0) ? rv_cyc[0] - rdy_cyc[0] : 99, 2);
        chk("rd1_re_cycles", re_cycles, 1);

        // Write from port 1 with three stalled cycles.
        clear_logs(); stall = 3;
        q1.push_back(mk(1'b0, 1'b1, 5'h1B, 8'hC5));
        wait_idle("wr1", 40);
        chk("wr1_we_cycles", we_cycles, 4);
        chk("wr1_re_cycles", re_cycles, 0);
        chk("wr1_ready_count", rdy_log.size(), 1);
        chk("wr1_ready_port", rdy_log.size() > 0 ? rdy_log[0] : 99, 1);
        chk("wr1_no_valid", rv_port.size(), 0);
        chk("wr1_mem", 32'(memory[5'h1B]), 32'hC5);

        // Two simultaneous read pairs after reset alternate port 0, port 1.
        do_reset();
        clear_logs(); stall = 0; rlat = 1;
        memory[3] = 8'h11; memory[4] = 8'h22; memory[6] = 8'h33; memory[7] = 8'h44;
        q0.push_back(mk(1'b1, 1'b0, 5'd3, 8'h00)); q0.push_back(mk(1'b1, 1'b0, 5'd6, 8'h00));
        q1.push_back(mk(1'b1, 1'b0, 5'd4, 8'h00)); q1.push_back(mk(1'b1, 1'b0, 5'd7, 8'h00));
        wait_idle("rr", 80);
        chk("rr_ready_count", rdy_log.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("rr_order", rdy_log.size() > i ? rdy_log[i] : 99, i % 2);
        chk("rr_d0", rv_data.size() > 0 ? rv_data[0] : 999, 32'h11);
        chk("rr_d1", rv_data.size() > 1 ? rv_data[1] : 999, 32'h22);
        chk("rr_d2", rv_data.size() > 2 ? rv_data[2] : 999, 32'h33);
        chk("rr_d3", rv_data.size() > 3 ? rv_data[3] : 999, 32'h44);

        // re and we together: write wins.
        clear_logs();
        q0.push_back(mk(1'b1, 1'b1, 5'h05, 8'h3C));
        wait_idle("rw", 40);
        chk("rw_we_cycles", we_cycles, 1);
        chk("rw_re_cycles", re_cycles, 0);
        chk("rw_no_valid", rv_port.size(), 0);
        chk("rw_mem", 32'(memory[5]), 32'h3C);

        // Reset while waiting for read data; the late valid must be dropped.
        clear_logs(); rlat = 6;
        q1.push_back(mk(1'b1, 1'b0, 5'd9, 8'h00));
        begin
            int n = 0;
            while (!(m_active && m_acc) && n < 40) begin @(posedge clk); n++; end
            chk("rst_mid_reached_rwait", 32'(n < 40), 32'd1);
        end
        @(posedge clk); #2; rst = 1'b1;
        @(posedge clk); #2; rst = 1'b0; extra_valid = 1'b1;
        @(posedge clk); #2; extra_valid = 1'b0;
        repeat (3) @(posedge clk);
        chk("rst_mid_no_valid", rv_port.size(), 0);
        chk("rst_mid_ready_count", rdy_log.size(), 1);
        clear_logs(); rlat = 1;
        q0.push_back(mk(1'b1, 1'b0, 5'd3, 8'h00));
        q1.push_back(mk(1'b1, 1'b0, 5'd4, 8'h00));
        wait_idle("rst_mid_next", 60);
        chk("rst_mid_first_grant", rdy_log.size() > 0 ? rdy_log[0] : 99, 0);

        // Four back-to-back writes from port 0 alone.
        clear_logs(); stall = 0;
        for (int i = 0; i < 4; i++) q0.push_back(mk(1'b0, 1'b1, 5'(10 + i), 8'(8'h80 + i)));
        wait_idle("b2b", 60);
        chk("b2b_ready_count", rdy_log.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("b2b_port", rdy_log.size() > i ? rdy_log[i] : 99, 0);
        for (int i = 1; i < 4; i++)
            chk("b2b_spacing", rdy_cyc.size() > i ? rdy_cyc[i] - rdy_cyc[i-1] : 99, 2);
        chk("b2b_we_cycles", we_cycles, 4);
        chk("b2b_mem", 32'(memory[13]), 32'h83);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NumPorts, default 2, number of requesting cache ports (2..8).
REQ-002 Parameter AddrBusWidth, default 5, width of the memory address.
REQ-003 Parameter MemBusWidth, default 8, width of the memory data bus.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 port_addr  input  [NumPorts] x AddrBusWidth  per-port request address.
REQ-007 port_w_data  input  [NumPorts] x MemBusWidth  per-port write data.
REQ-008 port_re / port_we  input  [NumPorts] x 1  per-port read / write request.
REQ-009 port_ready  output  [NumPorts] x 1  request accepted by memory (one-cycle pulse).
REQ-010 port_r_data  output  [NumPorts] x MemBusWidth  read data returned to the port.
REQ-011 port_r_data_valid  output  [NumPorts] x 1  port_r_data valid (one-cycle pulse).
REQ-012 mem_addr  output  AddrBusWidth  address to the shared memory.
REQ-013 mem_w_data  output  MemBusWidth  write data to memory.
REQ-014 mem_re / mem_we  output  1  read / write strobe to memory.
REQ-015 mem_ready  input  1  memory accepts the strobed request this cycle.
REQ-016 mem_r_data / mem_r_data_valid  input  MemBusWidth / 1  read return from memory.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, RWAIT.
REQ-018 Requesters SHALL hold re/we, addr and w_data stable until their port_ready pulse; the arbiter SHALL NOT buffer requests.
REQ-019 In IDLE, if any port has re or we, the arbiter SHALL grant one port round-robin: the search starts at (last_grant+1) mod NumPorts.
REQ-020 On grant, the arbiter SHALL register mem_addr, mem_w_data, mem_re and mem_we from the granted port and enter ISSUE; the strobe is visible in the cycle after the request is first seen.
REQ-021 If a port asserts re and we together, we SHALL win: mem_we=1, mem_re=0.
REQ-022 In ISSUE, mem_re/mem_we, mem_addr and mem_w_data SHALL hold until a cycle with mem_ready=1.
REQ-023 In that mem_ready cycle, port_ready[grant] SHALL be 1 (combinational) and all other port_ready bits 0.
REQ-024 On the accepting edge the strobes SHALL deassert; a write returns to IDLE and a read enters RWAIT.
REQ-025 In RWAIT, when mem_r_data_valid=1, port_r_data_valid[grant] SHALL be 1 that cycle and port_r_data[grant] SHALL equal mem_r_data (combinational pass-through); the FSM then returns to IDLE.
REQ-026 port_r_data of non-granted ports SHALL be 0 and their valid bits 0.
REQ-027 mem_r_data_valid outside RWAIT SHALL be ignored.
REQ-028 last_grant SHALL update at grant time; a lone requester SHALL be re-granted back-to-back.
REQ-029 Minimum occupancy SHALL be 2 cycles per write (IDLE, ISSUE) and 3 per read (IDLE, ISSUE, RWAIT).
REQ-030 Requests that change while not granted SHALL NOT affect the in-flight transaction.

Reset
REQ-031 With rst=1 at an edge: state=IDLE, last_grant=NumPorts-1 (so port 0 wins first), mem_re=mem_we=0, mem_addr=0, mem_w_data=0.
REQ-032 During reset: all port_ready and port_r_data_valid=0, and all port_r_data=0.
REQ-033 Reset mid-transaction SHALL abandon it without a ready or valid pulse; a late mem_r_data_valid SHALL be ignored.

Verification (NumPorts=2, AddrBusWidth=5, MemBusWidth=8)
REQ-034 Port1 re, addr=0x1B, mem_ready=1 immediately, mem_r_data=0xA7 valid 2 cycles later -> mem_re=1 with mem_addr=0x1B for one cycle, port_ready[1] pulses, then port_r_data[1]=0xA7 with port_r_data_valid[1] for one cycle.
REQ-035 Port1 we, addr=0x1B, w_data=0xC5, mem_ready held 0 for 3 cycles -> mem_we, 0x1B and 0xC5 stable for 4 cycles; port_ready[1] only in the mem_ready cycle; then IDLE.
REQ-036 Both ports request reads in the same cycle after reset, mem always ready -> port0 served first, then port1; a second simultaneous pair -> port0, then port1 (alternation).
REQ-037 Port0 asserts re and we, addr=0x05 -> mem_we=1, mem_re=0, and no port_r_data_valid.
REQ-038 rst asserted in RWAIT, then mem_r_data_valid pulses -> no port_r_data_valid; the next request is granted to port0.
REQ-039 Port0 issues 4 back-to-back writes alone -> each is granted to port0 with 2-cycle spacing and no idle gaps.
